// File: rtl/sci_rx_deser_pkg.sv
// sci_rx_deser_pkg: shared SCI receive types and the bit-counter width helper
package sci_rx_deser_pkg;
    typedef enum logic {IDLE, SHIFT} state_t;
    function automatic int cnt_w(input int depth);
        return ($clog2(depth) < 1) ? 1 : $clog2(depth);
    endfunction
endpackage

// File: rtl/sci_rx_deser_if.sv
// sci_rx_deser_if: serial input, parallel valid/ready output and sticky error flags of the SCI receiver
//   master: drives sin/sin_valid/sin_start/pout_ready/err_clr, observes pout/pout_valid/err_*
//   slave : the receiver side
interface sci_rx_deser_if #(parameter int DEPTH = 8);
    logic             sin;
    logic             sin_valid;
    logic             sin_start;
    logic [DEPTH-1:0] pout;
    logic             pout_valid;
    logic             pout_ready;
    logic             err_clr;
    logic             err_frame;
    logic             err_ovf;
    modport master (output sin, sin_valid, sin_start, pout_ready, err_clr,
                    input  pout, pout_valid, err_frame, err_ovf);
    modport slave  (input  sin, sin_valid, sin_start, pout_ready, err_clr,
                    output pout, pout_valid, err_frame, err_ovf);
endinterface

// File: rtl/sci_rx_deser_sipo.sv
// sipo_buffer: DEPTH-bit right-shift register, serial in at MSB, with enable and clear
//   i_clk, i_rst_n : clock, async active-low reset
//   i_en, i_clr    : shift enable; clear drops the held bits (combined with i_en the bit enters an empty register)
//   i_sin          : serial bit
//   o_pout         : word as it stands once the current enabled bit is included
module sipo_buffer #(parameter int DEPTH = 8) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic             i_sin,
    output logic [DEPTH-1:0] o_pout
);
    logic [DEPTH-1:0] r_sr;
    logic [DEPTH-1:0] w_base;
    logic [DEPTH-1:0] w_nxt;
    always_comb begin
        w_base = i_clr ? '0 : r_sr;
        w_nxt  = i_en ? {i_sin, w_base[DEPTH-1:1]} : w_base;
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_sr <= '0;
        else          r_sr <= w_nxt;
    end
    // Exposing the next value lets a completed word be captured in the same edge as its final bit
    assign o_pout = w_nxt;
endmodule

// File: rtl/sci_rx_deser.sv
// sci_rx_deser: SCI serial-to-parallel receive stage with output holding register and sticky errors
//   i_clk, i_rst_n : clock, async active-low reset
//   io_bus         : serial input, valid/ready word output, error clear and flags
module sci_rx_deser
    import sci_rx_deser_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    sci_rx_deser_if.slave  io_bus
);
    localparam int CW = cnt_w(DEPTH);
    state_t           r_state, w_state_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic             w_en, w_clr, w_done, w_frame_set, w_hold, w_load;
    logic [DEPTH-1:0] w_word, r_pout;
    logic             r_pout_valid, r_err_frame, r_err_ovf;
    sipo_buffer #(.DEPTH(DEPTH)) u_sipo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (w_en),
        .i_clr   (w_clr),
        .i_sin   (io_bus.sin),
        .o_pout  (w_word)
    );
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_en        = 1'b0;
        w_clr       = 1'b0;
        w_done      = 1'b0;
        w_frame_set = 1'b0;
        if (io_bus.sin_valid) begin
            if (io_bus.sin_start) begin
                // A start always begins a fresh word; inside SHIFT it also flags the abandoned one
                w_en        = 1'b1;
                w_clr       = 1'b1;
                w_cnt_nxt   = CW'(1);
                w_state_nxt = SHIFT;
                w_frame_set = (r_state == SHIFT);
            end else if (r_state == IDLE) begin
                w_frame_set = 1'b1;
            end else if (r_cnt == CW'(DEPTH - 1)) begin
                w_en        = 1'b1;
                w_done      = 1'b1;
                w_cnt_nxt   = '0;
                w_state_nxt = IDLE;
            end else begin
                w_en        = 1'b1;
                w_cnt_nxt   = r_cnt + CW'(1);
            end
        end
    end
    // A word waiting without ready is frozen; a completion then is dropped as overflow
    assign w_hold = r_pout_valid & ~io_bus.pout_ready;
    assign w_load = w_done & ~w_hold;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pout       <= '0;
            r_pout_valid <= 1'b0;
            r_err_frame  <= 1'b0;
            r_err_ovf    <= 1'b0;
        end else begin
            r_pout       <= w_load ? w_word : r_pout;
            r_pout_valid <= w_load | w_hold;
            r_err_frame  <= w_frame_set | (r_err_frame & ~io_bus.err_clr);
            r_err_ovf    <= (w_done & w_hold) | (r_err_ovf & ~io_bus.err_clr);
        end
    end
    assign io_bus.pout       = r_pout;
    assign io_bus.pout_valid = r_pout_valid;
    assign io_bus.err_frame  = r_err_frame;
    assign io_bus.err_ovf    = r_err_ovf;
endmodule

// File: tb/tb_sci_rx_deser.sv
// tb_sci_rx_deser: directed self-checking bench for sci_rx_deser with DEPTH=8
module tb_sci_rx_deser;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;
    sci_rx_deser_if #(.DEPTH(8)) bus ();
    sci_rx_deser #(.DEPTH(8)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_bus  (bus)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic bit_in(input logic b, input logic st);
        @(negedge clk);
        bus.sin       = b;
        bus.sin_valid = 1'b1;
        bus.sin_start = st;
    endtask
    task automatic idle_cyc();
        @(negedge clk);
        bus.sin_valid = 1'b0;
        bus.sin_start = 1'b0;
    endtask
    task automatic send_word(input logic [7:0] w, input logic rdy_last);
        for (int i = 0; i < 8; i++) begin
            bit_in(w[i], i == 0);
            if (i == 7 && rdy_last) bus.pout_ready = 1'b1;
        end
    endtask
    initial begin
        bus.sin = 1'b0;
        bus.sin_valid = 1'b0;
        bus.sin_start = 1'b0;
        bus.pout_ready = 1'b1;
        bus.err_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_pout", {24'd0, bus.pout}, 32'h0);
        chk("rst_valid", {31'd0, bus.pout_valid}, 32'h0);
        chk("rst_flags", {30'd0, bus.err_frame, bus.err_ovf}, 32'h0);
        rst_n = 1'b1;
        // 1: basic word, valid exactly one cycle with ready high
        send_word(8'hA5, 1'b0);
        chk("t1_pre_valid", {31'd0, bus.pout_valid}, 32'h0);
        idle_cyc();
        chk("t1_valid", {31'd0, bus.pout_valid}, 32'h1);
        chk("t1_pout", {24'd0, bus.pout}, 32'hA5);
        chk("t1_flags", {30'd0, bus.err_frame, bus.err_ovf}, 32'h0);
        idle_cyc();
        chk("t1_valid_drop", {31'd0, bus.pout_valid}, 32'h0);
        // 2: gapped strobe between bits 4 and 5
        for (int i = 0; i < 4; i++) bit_in(i == 2 || i == 3, i == 0);
        repeat (3) idle_cyc();
        for (int i = 4; i < 8; i++) bit_in(i == 4 || i == 5, 1'b0);
        idle_cyc();
        chk("t2_valid", {31'd0, bus.pout_valid}, 32'h1);
        chk("t2_pout", {24'd0, bus.pout}, 32'h3C);
        chk("t2_flags", {30'd0, bus.err_frame, bus.err_ovf}, 32'h0);
        idle_cyc();
        // 3: backpressure, second word dropped
        bus.pout_ready = 1'b0;
        send_word(8'h11, 1'b0);
        send_word(8'h22, 1'b0);
        idle_cyc();
        chk("t3_valid", {31'd0, bus.pout_valid}, 32'h1);
        chk("t3_pout_held", {24'd0, bus.pout}, 32'h11);
        chk("t3_ovf", {31'd0, bus.err_ovf}, 32'h1);
        bus.pout_ready = 1'b1;
        @(negedge clk);
        bus.pout_ready = 1'b0;
        chk("t3_valid_clr", {31'd0, bus.pout_valid}, 32'h0);
        chk("t3_ovf_sticky", {31'd0, bus.err_ovf}, 32'h1);
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        chk("t3_ovf_cleared", {31'd0, bus.err_ovf}, 32'h0);
        // 4: handshake in the cycle the final bit of the next word arrives
        send_word(8'h11, 1'b0);
        send_word(8'h22, 1'b1);
        chk("t4_valid_before", {31'd0, bus.pout_valid}, 32'h1);
        chk("t4_pout_before", {24'd0, bus.pout}, 32'h11);
        idle_cyc();
        chk("t4_valid", {31'd0, bus.pout_valid}, 32'h1);
        chk("t4_pout", {24'd0, bus.pout}, 32'h22);
        chk("t4_ovf", {31'd0, bus.err_ovf}, 32'h0);
        idle_cyc();
        chk("t4_valid_clr", {31'd0, bus.pout_valid}, 32'h0);
        // 5: premature start at bit 5, then a full 0xF0
        for (int i = 0; i < 5; i++) bit_in(1'b1, i == 0);
        send_word(8'hF0, 1'b0);
        idle_cyc();
        chk("t5_frame", {31'd0, bus.err_frame}, 32'h1);
        chk("t5_pout", {24'd0, bus.pout}, 32'hF0);
        chk("t5_valid", {31'd0, bus.pout_valid}, 32'h1);
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        chk("t5_frame_clr", {31'd0, bus.err_frame}, 32'h0);
        bit_in(1'b1, 1'b0);
        bus.err_clr = 1'b1;
        idle_cyc();
        bus.err_clr = 1'b0;
        chk("t5_set_wins", {31'd0, bus.err_frame}, 32'h1);
        chk("t5_stray_no_word", {31'd0, bus.pout_valid}, 32'h0);
        // 6: async reset mid-word with a held word and a set flag
        bus.pout_ready = 1'b0;
        send_word(8'h5A, 1'b0);
        idle_cyc();
        chk("t6_held", {24'd0, bus.pout}, 32'h5A);
        for (int i = 0; i < 4; i++) bit_in(1'b1, i == 0);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_pout", {24'd0, bus.pout}, 32'h0);
        chk("t6_rst_valid", {31'd0, bus.pout_valid}, 32'h0);
        chk("t6_rst_flags", {30'd0, bus.err_frame, bus.err_ovf}, 32'h0);
        idle_cyc();
        idle_cyc();
        rst_n = 1'b1;
        bus.pout_ready = 1'b1;
        send_word(8'h81, 1'b0);
        idle_cyc();
        chk("t6_valid", {31'd0, bus.pout_valid}, 32'h1);
        chk("t6_pout", {24'd0, bus.pout}, 32'h81);
        chk("t6_flags", {30'd0, bus.err_frame, bus.err_ovf}, 32'h0);
        idle_cyc();
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/sci_rx_deser.md
Name: sci_rx_deser

Overview:
Serial-in/parallel-out receive stage for the SCI serial link, downstream of the parallel-in/serial-out transmit buffer. It samples the LSB-first serial stream qualified by a per-bit strobe and a start-of-word marker. It assembles DEPTH-bit words and presents them on a valid/ready parallel interface. An output holding register lets the next word shift in while the previous one waits. Framing and overflow errors are reported as sticky flags.

Parameters:
DEPTH, 8, word width in bits; legal range >= 2, must match the transmit buffer depth.

Ports:
CLK  input  1  single clock, rising edge.
RSTN  input  1  asynchronous active-low reset; all state clears immediately on assertion, deassertion synchronous to CLK.
SIN  input  1  serial data bit, LSB first.
SIN_VALID  input  1  qualifies SIN this cycle; one bit consumed per asserted cycle.
SIN_START  input  1  marks the current SIN bit as bit 0 of a new word; meaningful only with SIN_VALID.
POUT  output  DEPTH  assembled word, stable while POUT_VALID=1.
POUT_VALID  output  1  POUT holds an unconsumed word.
POUT_READY  input  1  consumer accepts the word when POUT_VALID & POUT_READY.
ERR_CLR  input  1  clears both sticky error flags.
ERR_FRAME  output  1  sticky: a word boundary was violated.
ERR_OVF  output  1  sticky: a completed word was dropped.

Behaviour:
- Reset values: POUT=0, POUT_VALID=0, ERR_FRAME=0, ERR_OVF=0, state IDLE, bit counter 0, shift register 0.
- Shift register: on each accepted bit it shifts right and the new bit enters at MSB. After DEPTH bits, the first bit received sits at POUT[0].
- Bit counter: width $clog2(DEPTH), counts 0..DEPTH-1, no wrap beyond DEPTH-1.
- FSM states:
  - IDLE:
    - SIN_VALID & SIN_START: shift bit in, counter=1, go to SHIFT.
    - SIN_VALID & !SIN_START: bit discarded, ERR_FRAME set, stay in IDLE.
    - No SIN_VALID: stay in IDLE.
  - SHIFT:
    - SIN_VALID & SIN_START: premature start. Set ERR_FRAME, discard the partial word, take this bit as bit 0, counter=1, stay in SHIFT.
    - SIN_VALID & !SIN_START & counter<DEPTH-1: shift bit in, counter++.
    - SIN_VALID & !SIN_START & counter==DEPTH-1: shift final bit in, word complete, counter=0, go to IDLE.
    - No SIN_VALID: hold all state, with no timeout.
- Word completion and the output register:
  - The completed word (the shift register including the final bit) is written to POUT.
  - POUT_VALID rises on the clock edge after the cycle the final bit is sampled, i.e. 1-cycle latency from last SIN_VALID.
  - The completion logic writes the new word into POUT, not the stale shift register.
- Handshake:
  - POUT_VALID clears on the edge after POUT_VALID & POUT_READY, unless a new word completes in that same cycle.
  - If a word completes in the same cycle as a handshake, the new word loads and POUT_VALID stays 1.
  - POUT and POUT_VALID must not change while POUT_VALID=1 & POUT_READY=0, except through reset.
- Overflow:
  - If a word completes while POUT_VALID=1 & POUT_READY=0, the new word is dropped.
  - POUT keeps the old word and ERR_OVF is set.
  - The FSM still returns to IDLE.
- Sticky flags:
  - Set conditions and ERR_CLR are evaluated in the same cycle; a set wins over a clear.
  - Flags never affect data flow.
- Reset mid-word: the partial word is lost, any held POUT word is lost, and no flag is set.

Decomposition:
- Shared SCI package:
  - FSM state enum (IDLE, SHIFT).
  - Function for the counter width, with a lower bound of 1.
- Natural sub-module: sipo_buffer.
  - DEPTH-bit right-shift register with EN and clear.
  - Serial in at MSB, parallel out.
  - It is the mirror of the transmit buffer and is reusable elsewhere in SCI.
- FSM, counter, output register and flags stay in sci_rx_deser.

Test Plan:
All scenarios use DEPTH=8.
1. Basic word: send 0xA5 LSB first (bits 1,0,1,0,0,1,0,1), SIN_START on the first bit, SIN_VALID continuous, POUT_READY=1. Expect POUT=0xA5 and POUT_VALID=1 for exactly 1 cycle, asserted the edge after the 8th bit; no flags.
2. Gapped strobe: send 0x3C with SIN_VALID low for 3 cycles between bits 4 and 5. Expect POUT=0x3C one cycle after the last valid bit; no flags.
3. Back-to-back with backpressure: 0x11 then 0x22 contiguous, POUT_READY=0. Expect 0x11 held, 0x22 dropped, ERR_OVF=1. Then POUT_READY=1 for 1 cycle, after which POUT_VALID=0.
4. Same-cycle handshake and completion: POUT_READY asserted in the cycle the last bit of 0x22 arrives, with 0x11 held. Expect POUT=0x22 next cycle, POUT_VALID continuously 1, ERR_OVF=0.
5. Framing: SIN_START re-asserted at bit 5 of a word, followed by a full 0xF0. Expect ERR_FRAME=1 and POUT=0xF0. Assert ERR_CLR to clear the flag. ERR_CLR coincident with a stray non-start bit in IDLE leaves ERR_FRAME=1.
6. Reset mid-operation: assert RSTN=0 asynchronously after 4 bits of a word with 0x5A held on POUT. Expect all outputs 0 immediately. After release, a fresh 0x81 is received correctly.
